rx_deserialiser_n: RTL and testbench

- Converts the bit-by-bit Rx stream (soc/eoc/data/data_valid/error, one bit per pulse) into W-bit words.
- A partial final word is flagged through data_bits.
- Sits between the Rx decoder and the frame/command layer.
- Generalises the fixed 8-bit path to any power-of-two word width, selectable bit order, and optional in-line parity checking.

---
 rtl/rx_deserialiser_n_pkg.sv | 23 ++
 rtl/rx_deserialiser_n_if.sv | 34 +++
 rtl/rx_deserialiser_n_acc.sv | 53 +++++
 rtl/rx_deserialiser_n.sv | 149 ++++++++++++++
 tb/tb_rx_deserialiser_n.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_deserialiser_n_pkg.sv
// rx_deser_pkg: shared types and helpers for the rx_deserialiser_n slice.
//   state_e       - FSM state encoding (IDLE, RX, PAR).
//   cnt_width()   - width of the in-word bit counter for a W-bit word.
//   odd_parity_ok - 1 when 8 data bits plus parity bit have odd weight.
package rx_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    // Counter holds 0..W-1, so $clog2(W) bits; never narrower than 1 bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    // ISO 14443A frames use odd parity over data + parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/rx_deserialiser_n_if.sv
// rx_deserialiser_n_if: bit-stream input and word output bundle.
//   in_*  : soc/eoc/data/data_valid/error pulses from the Rx decoder.
//   out_* : soc/eoc/data[W]/data_valid/data_bits/error towards the frame layer.
//   master modport drives in_* (decoder side), slave modport is the deserialiser.
interface rx_deserialiser_n_if
    import rx_deser_pkg::*;
#(
    parameter int W = 8
);
    localparam int CW = cnt_width(W);

    logic          in_soc;
    logic          in_eoc;
    logic          in_data;
    logic          in_data_valid;
    logic          in_error;
    logic          out_soc;
    logic          out_eoc;
    logic [W-1:0]  out_data;
    logic          out_data_valid;
    logic [CW-1:0] out_data_bits;
    logic          out_error;

    modport master (
        output in_soc, in_eoc, in_data, in_data_valid, in_error,
        input  out_soc, out_eoc, out_data, out_data_valid, out_data_bits, out_error
    );

    modport slave (
        input  in_soc, in_eoc, in_data, in_data_valid, in_error,
        output out_soc, out_eoc, out_data, out_data_valid, out_data_bits, out_error
    );

endinterface

// File: rtl/rx_deserialiser_n_acc.sv
// rx_bit_accumulator: collects single bits into a W-bit word.
//   clear    - drop the partial word, count back to 0.
//   shift_en - bit_in is a data bit this cycle.
//   bit_in   - the data bit.
//   word     - current word including this cycle's bit, unfilled bits zero.
//   count    - bits held before this cycle (0..W-1).
//   full     - this cycle's bit completes the word; count wraps to 0.
// MSB_FIRST=0 places bit n at word[n]; MSB_FIRST=1 places it at word[W-1-n],
// so a partial word is packed from the LSB or MSB side respectively.
module rx_bit_accumulator
    import rx_deser_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = cnt_width(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          shift_en,
    input  logic          bit_in,
    output logic [W-1:0]  word,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [W-1:0]  sreg;
    logic [CW-1:0] pos;

    // Bits are written in place rather than shifted, which keeps the
    // unfilled part zero without a final alignment step.
    assign pos  = MSB_FIRST ? (CW'(W - 1) - count) : count;
    assign full = shift_en && (count == CW'(W - 1));

    always_comb begin
        word = sreg;
        if (shift_en) word[pos] = bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            count <= '0;
        end else if (clear || full) begin
            sreg  <= '0;
            count <= '0;
        end else if (shift_en) begin
            sreg  <= word;
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/rx_deserialiser_n.sv
// rx_deserialiser_n: turns the one-bit-per-pulse Rx stream into W-bit words.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : rx_deserialiser_n_if.slave (in_* from decoder, out_* to frame layer).
// Parameters: W (power of two, 2..32), MSB_FIRST (bit order).
// Optional build macro RX_PARITY_CHECK_EN: after each 8-bit word the next bit
// is an odd-parity bit; a bad or missing parity bit aborts the frame.
// All outputs are registered one-cycle pulses; out_data and out_data_bits
// hold between pulses.
module rx_deserialiser_n
    import rx_deser_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    rx_deserialiser_n_if.slave bus
);

    localparam int CW = cnt_width(W);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RX   = ST_RX;
`ifdef RX_PARITY_CHECK_EN
    localparam logic [1:0] S_PAR  = ST_PAR;
`endif

    if ((W < 2) || (W > 32) || ((W & (W - 1)) != 0)) begin : g_bad_w
        $error("rx_deserialiser_n: W must be a power of two in 2..32");
    end
`ifdef RX_PARITY_CHECK_EN
    if (W != 8) begin : g_bad_par
        $error("rx_deserialiser_n: parity checking requires W == 8");
    end
`endif

    logic [1:0]    state;
    logic          soc_q, eoc_q, dv_q, err_q;
    logic [W-1:0]  data_q;
    logic [CW-1:0] bits_q;

    logic          acc_clear, acc_shift, acc_full;
    logic [W-1:0]  acc_word;
    logic [CW-1:0] acc_cnt;
    logic          ctrl_evt;

`ifdef RX_PARITY_CHECK_EN
    logic [W-1:0]  hold_q;    // completed word waiting for its parity bit
`endif

    // Any control pulse beats a data bit arriving the same cycle.
    assign ctrl_evt  = bus.in_soc || bus.in_error || bus.in_eoc;
    assign acc_shift = (state == S_RX) && !ctrl_evt && bus.in_data_valid;
    // Outside RX the accumulator is idle-empty; keeping it cleared there
    // means every frame starts from count 0.
    assign acc_clear = (state != S_RX) || ctrl_evt;

    rx_bit_accumulator #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (acc_clear),
        .shift_en (acc_shift),
        .bit_in   (bus.in_data),
        .word     (acc_word),
        .count    (acc_cnt),
        .full     (acc_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            soc_q  <= 1'b0;
            eoc_q  <= 1'b0;
            dv_q   <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            bits_q <= '0;
`ifdef RX_PARITY_CHECK_EN
            hold_q <= '0;
`endif
        end else begin
            soc_q <= 1'b0;
            eoc_q <= 1'b0;
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.in_soc) begin
                    soc_q <= 1'b1;
                    state <= S_RX;
                end
            end else if (bus.in_soc) begin
                // Restart: partial word dropped silently.
                soc_q <= 1'b1;
                state <= S_RX;
            end else if (bus.in_error) begin
                err_q <= 1'b1;
                eoc_q <= bus.in_eoc;
                state <= S_IDLE;
            end else if (bus.in_eoc) begin
                eoc_q <= 1'b1;
`ifdef RX_PARITY_CHECK_EN
                if (state == S_PAR) begin
                    err_q <= 1'b1;       // frame ended before the parity bit
                end else
`endif
                if (acc_cnt != '0) begin
                    dv_q   <= 1'b1;
                    data_q <= acc_word;
                    bits_q <= acc_cnt;
                end
                state <= S_IDLE;
            end else if (bus.in_data_valid) begin
`ifdef RX_PARITY_CHECK_EN
                if (state == S_PAR) begin
                    if (odd_parity_ok(hold_q, bus.in_data)) begin
                        dv_q   <= 1'b1;
                        data_q <= hold_q;
                        bits_q <= '0;
                        state  <= S_RX;
                    end else begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end
                end else if (acc_full) begin
                    hold_q <= acc_word;
                    state  <= S_PAR;
                end
`else
                if (acc_full) begin
                    dv_q   <= 1'b1;
                    data_q <= acc_word;
                    bits_q <= '0;
                end
`endif
            end
        end
    end

    assign bus.out_soc        = soc_q;
    assign bus.out_eoc        = eoc_q;
    assign bus.out_data_valid = dv_q;
    assign bus.out_error      = err_q;
    assign bus.out_data       = data_q;
    assign bus.out_data_bits  = bits_q;

endmodule

// File: tb/tb_rx_deserialiser_n.sv
// tb_rx_deserialiser_n: two deserialisers (W=8 LSB-first, and W=16 MSB-first,
// or W=8 MSB-first when parity checking is built in) share one input stream.
// A frame-level model predicts each output cycle; directed frames with
// hand-computed words pin the model, then a long random stream follows.
module tb_rx_deserialiser_n;

`ifdef RX_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
    localparam int WB  = 8;
`else
    localparam bit PAR = 1'b0;
    localparam int WB  = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_soc = 1'b0, s_eoc = 1'b0, s_dv = 1'b0, s_d = 1'b0, s_err = 1'b0;
    bit   chk_on = 1'b0;
    int   checks = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    rx_deserialiser_n_if #(.W(8))  ifa ();
    rx_deserialiser_n_if #(.W(WB)) ifb ();

    assign ifa.in_soc = s_soc;  assign ifb.in_soc = s_soc;
    assign ifa.in_eoc = s_eoc;  assign ifb.in_eoc = s_eoc;
    assign ifa.in_data = s_d;   assign ifb.in_data = s_d;
    assign ifa.in_data_valid = s_dv; assign ifb.in_data_valid = s_dv;
    assign ifa.in_error = s_err; assign ifb.in_error = s_err;

    rx_deserialiser_n #(.W(8), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rx_deserialiser_n #(.W(WB), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // ---------------- model: [0] = W8 LSB-first, [1] = WB MSB-first ----------
    int          mode[2];     // 0 idle, 1 in frame, 2 waiting for parity bit
    int          k[2];        // bits received in the current word
    bit          fb[2][32];   // received bits of the current word, in order
    logic [31:0] hold[2];
    logic        e_soc[2], e_eoc[2], e_dv[2], e_err[2];
    logic [31:0] e_data[2];
    int          e_bits[2];

    // i-th received bit sits at position i, or W-1-i when MSB first.
    function automatic logic [31:0] pack(input int m, input int n, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[(m == 1) ? (w - 1 - i) : i] = fb[m][i];
        return r;
    endfunction

    task automatic model_step(input int m);
        int w;
        w = (m == 0) ? 8 : WB;
        e_soc[m] = 0; e_eoc[m] = 0; e_dv[m] = 0; e_err[m] = 0;
        if (s_soc) begin
            e_soc[m] = 1; mode[m] = 1; k[m] = 0;
        end else if (mode[m] != 0) begin
            if (s_err) begin
                e_err[m] = 1; e_eoc[m] = s_eoc; mode[m] = 0;
            end else if (s_eoc) begin
                e_eoc[m] = 1;
                if (mode[m] == 2) e_err[m] = 1;
                else if (k[m] > 0) begin
                    e_dv[m] = 1; e_data[m] = pack(m, k[m], w); e_bits[m] = k[m];
                end
                mode[m] = 0;
            end else if (s_dv) begin
                if (mode[m] == 2) begin
                    if (($countones({hold[m][7:0], s_d}) % 2) == 1) begin
                        e_dv[m] = 1; e_data[m] = hold[m]; e_bits[m] = 0; mode[m] = 1;
                    end else begin
                        e_err[m] = 1; mode[m] = 0;
                    end
                end else begin
                    fb[m][k[m]] = s_d;
                    k[m]++;
                    if (k[m] == w) begin
                        k[m] = 0;
                        if (PAR) begin
                            hold[m] = pack(m, w, w); mode[m] = 2;
                        end else begin
                            e_dv[m] = 1; e_data[m] = pack(m, w, w); e_bits[m] = 0;
                        end
                    end
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mode[m] = 0; k[m] = 0; hold[m] = '0;
                e_soc[m] = 0; e_eoc[m] = 0; e_dv[m] = 0; e_err[m] = 0;
                e_data[m] = '0; e_bits[m] = 0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_flags", {ifa.out_soc, ifa.out_eoc, ifa.out_data_valid, ifa.out_error},
                {e_soc[0], e_eoc[0], e_dv[0], e_err[0]});
            chk("a_data", 64'(ifa.out_data), 64'(e_data[0]));
            if (e_dv[0]) chk("a_bits", 64'(ifa.out_data_bits), 64'(e_bits[0]));
            chk("b_flags", {ifb.out_soc, ifb.out_eoc, ifb.out_data_valid, ifb.out_error},
                {e_soc[1], e_eoc[1], e_dv[1], e_err[1]});
            chk("b_data", 64'(ifb.out_data), 64'(e_data[1]));
            if (e_dv[1]) chk("b_bits", 64'(ifb.out_data_bits), 64'(e_bits[1]));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the next negedge, where the outputs
    // produced by these inputs are visible.
    task automatic drive(input logic soc, input logic eoc, input logic dv,
                         input logic d, input logic err);
        s_soc = soc; s_eoc = eoc; s_dv = dv; s_d = d; s_err = err;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit msb);
        for (int i = 0; i < n; i++) drive(0, 0, 1, msb ? v[n - 1 - i] : v[i], 0);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse();
        s_soc = 0; s_eoc = 0; s_dv = 0; s_d = 0; s_err = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_a", {ifa.out_soc, ifa.out_eoc, ifa.out_data_valid, ifa.out_error,
                            ifa.out_data_bits, ifa.out_data}, '0);
        chk("rst_async_b", {ifb.out_soc, ifb.out_eoc, ifb.out_data_valid, ifb.out_error,
                            ifb.out_data_bits, ifb.out_data}, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int  r;
        logic b;
        @(posedge clk);
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state_a", {ifa.out_soc, ifa.out_eoc, ifa.out_data_valid, ifa.out_error,
                              ifa.out_data_bits, ifa.out_data}, '0);
        chk("reset_state_b", {ifb.out_soc, ifb.out_eoc, ifb.out_data_valid, ifb.out_error,
                              ifb.out_data_bits, ifb.out_data}, '0);
        rst_n = 1'b1;
        idle();

        // Bits before any soc are ignored.
        send_bits(32'hFF, 8, 0);
        chk("pre_soc_no_dv", ifa.out_data_valid, 1'b0);

        drive(1, 0, 0, 0, 0);
        chk("soc_pulse", {ifa.out_soc, ifa.out_eoc, ifa.out_data_valid, ifa.out_error}, 4'b1000);
`ifndef RX_PARITY_CHECK_EN
        // 1,0,1,0,0,0,0,1 LSB first -> 0x85, then a bare eoc.
        send_bits(32'h85, 8, 0);
        chk("w85_flags", {ifa.out_soc, ifa.out_eoc, ifa.out_data_valid, ifa.out_error}, 4'b0010);
        chk("w85_data", ifa.out_data, 8'h85);
        chk("w85_bits", ifa.out_data_bits, 3'd0);
        drive(0, 1, 0, 0, 0);
        chk("w85_eoc_alone", {ifa.out_soc, ifa.out_eoc, ifa.out_data_valid, ifa.out_error}, 4'b0100);
        idle();
`else
        // 0x93 has four ones: parity 1 accepts, parity 0 rejects.
        send_bits(32'h93, 8, 0);
        chk("par_hold_no_dv", ifa.out_data_valid, 1'b0);
        drive(0, 0, 1, 1, 0);
        chk("par_ok_dv", {ifa.out_data_valid, ifa.out_error}, 2'b10);
        chk("par_ok_data", ifa.out_data, 8'h93);
        send_bits(32'h93, 8, 0);
        drive(0, 0, 1, 0, 0);
        chk("par_bad_err", {ifa.out_data_valid, ifa.out_error}, 2'b01);
        send_bits(32'h5A, 8, 0);
        drive(0, 0, 1, 0, 0);
        chk("par_after_err_ignored", {ifa.out_data_valid, ifa.out_error}, 2'b00);
        drive(0, 1, 0, 0, 0);
        chk("par_after_err_eoc_ignored", ifa.out_eoc, 1'b0);
        idle();
`endif

        // REQA short frame: 0,1,1,0,0,1,0 -> 0x26 with 7 valid bits.
        drive(1, 0, 0, 0, 0);
        send_bits(32'h26, 7, 0);
        drive(0, 1, 0, 0, 0);
        chk("reqa_flags", {ifa.out_soc, ifa.out_eoc, ifa.out_data_valid, ifa.out_error}, 4'b0110);
        chk("reqa_data", ifa.out_data, 8'h26);
        chk("reqa_bits", ifa.out_data_bits, 3'd7);
        idle();

`ifndef RX_PARITY_CHECK_EN
        // 20 bits MSB first into W=16: 0xA5C3 then 1,0,1,1 -> 0xB000 with 4 bits.
        drive(1, 0, 0, 0, 0);
        send_bits(32'hA5C3, 16, 1);
        chk("w16_word1_dv", ifb.out_data_valid, 1'b1);
        chk("w16_word1_data", ifb.out_data, 16'hA5C3);
        chk("w16_word1_bits", ifb.out_data_bits, 4'd0);
        send_bits(32'hB, 4, 1);
        drive(0, 1, 0, 0, 0);
        chk("w16_tail_flags", {ifb.out_soc, ifb.out_eoc, ifb.out_data_valid, ifb.out_error}, 4'b0110);
        chk("w16_tail_data", ifb.out_data, 16'hB000);
        chk("w16_tail_bits", ifb.out_data_bits, 4'd4);
        idle();
`endif

        // Error mid-word: error pulse only, next frame starts clean.
        drive(1, 0, 0, 0, 0);
        send_bits(32'h7, 3, 0);
        drive(0, 0, 0, 0, 1);
        chk("err_flags", {ifa.out_soc, ifa.out_eoc, ifa.out_data_valid, ifa.out_error}, 4'b0001);
        drive(1, 0, 0, 0, 0);
        send_bits(32'h26, 7, 0);
        drive(0, 1, 0, 0, 0);
        chk("after_err_data", ifa.out_data, 8'h26);
        chk("after_err_bits", ifa.out_data_bits, 3'd7);
        idle();

        // Async reset mid-word with a nonzero held word; data ignored after.
        drive(1, 0, 0, 0, 0);
        send_bits(32'h3C, 8, 0);
        send_bits(32'h3, 2, 0);
        reset_pulse();
        send_bits(32'hC3, 8, 0);
        chk("post_rst_ignored", {ifa.out_data_valid, ifa.out_data}, '0);
        idle();

        // Random stream, mixing legal traffic with illegal combinations.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            b = 1'($urandom_range(0, 1));
            if (i == 2000) reset_pulse();
            if      (r < 64) drive(0, 0, 1, b, 0);
            else if (r < 74) drive(0, 0, 0, 0, 0);
            else if (r < 79) drive(1, 0, 0, 0, 0);
            else if (r < 84) drive(0, 1, 0, 0, 0);
            else if (r < 87) drive(0, 1, 1, b, 0);
            else if (r < 89) drive(1, 0, 1, b, 0);
            else if (r < 92) drive(0, 0, 0, 0, 1);
            else if (r < 94) drive(0, 1, 0, 0, 1);
            else if (r < 96) drive(0, 0, 1, b, 1);
            else             drive(1, 0, 0, 0, 0);
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
